// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions: sizing, entry type codes and entry layout.
package rob_pkg;

    localparam int ROB_SIZE  = 8;
    localparam int ROB_WIDTH = 3;

    typedef logic [ROB_WIDTH-1:0] rob_id_t;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_HALT   = 2'd3
    } rob_type_e;

    // One in-flight instruction. For branches, value holds the resolved next PC.
    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] predAddr;
    } rob_entry_t;

    // Circular pointer advance; the wrap falls out of the power-of-two width.
    function automatic rob_id_t robNext(input rob_id_t id);
        return id + rob_id_t'(1);
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: keeps issued instructions in program order, captures results
// broadcast by the reservation station and load/store buffer, and retires the
// head entry once its result is known. A mispredicted branch at retire raises a
// one-cycle global clear carrying the redirect PC.
module rob
    import rob_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] issue_rob_id,

    input  logic                 dec_ready,
    input  logic [1:0]           dec_type,
    input  logic [4:0]           dec_rd,
    input  logic                 dec_has_value,
    input  logic [31:0]          dec_value,
    input  logic [31:0]          dec_pred_addr,

    input  logic                 rs_ready,
    input  logic [ROB_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]          rs_value,

    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,

    input  logic [ROB_WIDTH-1:0] qj_id,
    input  logic [ROB_WIDTH-1:0] qk_id,
    output logic                 qj_ready,
    output logic                 qk_ready,
    output logic [31:0]          qj_value,
    output logic [31:0]          qk_value,

    output logic                 commit_valid,
    output logic [4:0]           commit_rd,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic [31:0]          commit_value,

    output logic                 store_commit,
    output logic [ROB_WIDTH-1:0] store_rob_id,

    output logic [ROB_WIDTH-1:0] head_rob_id,

    output logic                 clear,
    output logic [31:0]          clear_pc,
    output logic                 halt
);

    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH+1)'(ROB_SIZE);
    localparam logic [ROB_WIDTH:0] COUNT_ONE  = (ROB_WIDTH+1)'(1);

    rob_entry_t          entryQ [ROB_SIZE];
    rob_entry_t          entryD [ROB_SIZE];
    rob_id_t             headQ, headD;
    rob_id_t             tailQ, tailD;
    logic [ROB_WIDTH:0]  countQ, countD;

    logic                commitValidQ, commitValidD;
    logic [4:0]          commitRdQ, commitRdD;
    rob_id_t             commitRobIdQ, commitRobIdD;
    logic [31:0]         commitValueQ, commitValueD;
    logic                storeCommitQ, storeCommitD;
    rob_id_t             storeRobIdQ, storeRobIdD;
    logic                clearQ, clearD;
    logic [31:0]         clearPcQ, clearPcD;
    logic                haltQ, haltD;

    logic                isFull;
    logic                isEmpty;
    rob_entry_t          headEntry;
    logic                canCommit;
    logic                doIssue;

    // Occupancy comes from the explicit count so full and empty never alias.
    always_comb begin
        isFull    = (countQ == FULL_COUNT);
        isEmpty   = (countQ == '0);
        headEntry = entryQ[headQ];
        canCommit = !clearQ && !haltQ && !isEmpty && headEntry.busy && headEntry.ready;
        doIssue   = dec_ready && !clearQ && (!isFull || canCommit);
    end

    // Next state: flush on clear, otherwise broadcasts, then retire, then issue
    // so a new entry overwrites whatever the other two did to the same slot.
    always_comb begin
        entryD       = entryQ;
        headD        = headQ;
        tailD        = tailQ;
        countD       = countQ;
        commitValidD = 1'b0;
        commitRdD    = commitRdQ;
        commitRobIdD = commitRobIdQ;
        commitValueD = commitValueQ;
        storeCommitD = 1'b0;
        storeRobIdD  = storeRobIdQ;
        clearD       = 1'b0;
        clearPcD     = clearPcQ;
        haltD        = haltQ;

        if (clearQ) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entryD[i].busy  = 1'b0;
                entryD[i].ready = 1'b0;
            end
            headD  = '0;
            tailD  = '0;
            countD = '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (rs_ready && (rs_rob_id == rob_id_t'(i)) && entryQ[i].busy) begin
                    entryD[i].ready = 1'b1;
                    entryD[i].value = rs_value;
                end
                if (lsb_ready && (lsb_rob_id == rob_id_t'(i)) && entryQ[i].busy) begin
                    entryD[i].ready = 1'b1;
                    entryD[i].value = lsb_value;
                end
            end

            if (canCommit) begin
                entryD[headQ].busy  = 1'b0;
                entryD[headQ].ready = 1'b0;
                headD               = robNext(headQ);
                case (headEntry.kind)
                    ROB_REG: begin
                        commitValidD = 1'b1;
                        commitRdD    = headEntry.rd;
                        commitRobIdD = headQ;
                        commitValueD = headEntry.value;
                    end
                    ROB_STORE: begin
                        storeCommitD = 1'b1;
                        storeRobIdD  = headQ;
                    end
                    ROB_BRANCH: begin
                        if (headEntry.value != headEntry.predAddr) begin
                            clearD   = 1'b1;
                            clearPcD = headEntry.value;
                        end
                    end
                    ROB_HALT: begin
                        haltD = 1'b1;
                    end
                    default: begin
                        haltD = haltQ;
                    end
                endcase
            end

            if (doIssue) begin
                entryD[tailQ].busy     = 1'b1;
                entryD[tailQ].ready    = dec_has_value;
                entryD[tailQ].kind     = rob_type_e'(dec_type);
                entryD[tailQ].rd       = dec_rd;
                entryD[tailQ].value    = dec_value;
                entryD[tailQ].predAddr = dec_pred_addr;
                tailD                  = robNext(tailQ);
            end

            case ({doIssue, canCommit})
                2'b10:   countD = countQ + COUNT_ONE;
                2'b01:   countD = countQ - COUNT_ONE;
                default: countD = countQ;
            endcase
        end
    end

    // State update; reset wins, and a low rdy_in freezes every register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entryQ[i] <= '0;
            end
            headQ        <= '0;
            tailQ        <= '0;
            countQ       <= '0;
            commitValidQ <= 1'b0;
            commitRdQ    <= '0;
            commitRobIdQ <= '0;
            commitValueQ <= '0;
            storeCommitQ <= 1'b0;
            storeRobIdQ  <= '0;
            clearQ       <= 1'b0;
            clearPcQ     <= '0;
            haltQ        <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entryQ[i] <= entryD[i];
            end
            headQ        <= headD;
            tailQ        <= tailD;
            countQ       <= countD;
            commitValidQ <= commitValidD;
            commitRdQ    <= commitRdD;
            commitRobIdQ <= commitRobIdD;
            commitValueQ <= commitValueD;
            storeCommitQ <= storeCommitD;
            storeRobIdQ  <= storeRobIdD;
            clearQ       <= clearD;
            clearPcQ     <= clearPcD;
            haltQ        <= haltD;
        end
    end

    // Operand lookup for qj: a same-cycle broadcast beats the stored result, rs first.
    always_comb begin
        qj_ready = entryQ[qj_id].ready;
        qj_value = entryQ[qj_id].value;
        if (lsb_ready && (lsb_rob_id == qj_id)) begin
            qj_ready = 1'b1;
            qj_value = lsb_value;
        end
        if (rs_ready && (rs_rob_id == qj_id)) begin
            qj_ready = 1'b1;
            qj_value = rs_value;
        end
    end

    // Operand lookup for qk, same priority as qj.
    always_comb begin
        qk_ready = entryQ[qk_id].ready;
        qk_value = entryQ[qk_id].value;
        if (lsb_ready && (lsb_rob_id == qk_id)) begin
            qk_ready = 1'b1;
            qk_value = lsb_value;
        end
        if (rs_ready && (rs_rob_id == qk_id)) begin
            qk_ready = 1'b1;
            qk_value = rs_value;
        end
    end

    assign rob_full      = isFull;
    assign issue_rob_id  = tailQ;
    assign head_rob_id   = headQ;
    assign commit_valid  = commitValidQ;
    assign commit_rd     = commitRdQ;
    assign commit_rob_id = commitRobIdQ;
    assign commit_value  = commitValueQ;
    assign store_commit  = storeCommitQ;
    assign store_rob_id  = storeRobIdQ;
    assign clear         = clearQ;
    assign clear_pc      = clearPcQ;
    assign halt          = haltQ;

endmodule

// File: tb/tb_rob.sv
// Directed testbench for the reorder buffer: in-order retire, full/wrap,
// mispredict flush, operand bypass, reset, rdy_in freeze, store and halt.
module tb_rob;

    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [1:0] T_HALT   = 2'd3;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_full;
    logic [2:0]  issue_rob_id;
    logic        dec_ready;
    logic [1:0]  dec_type;
    logic [4:0]  dec_rd;
    logic        dec_has_value;
    logic [31:0] dec_value;
    logic [31:0] dec_pred_addr;
    logic        rs_ready;
    logic [2:0]  rs_rob_id;
    logic [31:0] rs_value;
    logic        lsb_ready;
    logic [2:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic [2:0]  qj_id;
    logic [2:0]  qk_id;
    logic        qj_ready;
    logic        qk_ready;
    logic [31:0] qj_value;
    logic [31:0] qk_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [2:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        store_commit;
    logic [2:0]  store_rob_id;
    logic [2:0]  head_rob_id;
    logic        clear;
    logic [31:0] clear_pc;
    logic        halt;

    int checkCount = 0;
    int passCount  = 0;

    rob dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_full      (rob_full),
        .issue_rob_id  (issue_rob_id),
        .dec_ready     (dec_ready),
        .dec_type      (dec_type),
        .dec_rd        (dec_rd),
        .dec_has_value (dec_has_value),
        .dec_value     (dec_value),
        .dec_pred_addr (dec_pred_addr),
        .rs_ready      (rs_ready),
        .rs_rob_id     (rs_rob_id),
        .rs_value      (rs_value),
        .lsb_ready     (lsb_ready),
        .lsb_rob_id    (lsb_rob_id),
        .lsb_value     (lsb_value),
        .qj_id         (qj_id),
        .qk_id         (qk_id),
        .qj_ready      (qj_ready),
        .qk_ready      (qk_ready),
        .qj_value      (qj_value),
        .qk_value      (qk_value),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .store_commit  (store_commit),
        .store_rob_id  (store_rob_id),
        .head_rob_id   (head_rob_id),
        .clear         (clear),
        .clear_pc      (clear_pc),
        .halt          (halt)
    );

    // Free-running 10-unit clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        dec_ready     = 1'b0;
        dec_type      = 2'd0;
        dec_rd        = 5'd0;
        dec_has_value = 1'b0;
        dec_value     = 32'd0;
        dec_pred_addr = 32'd0;
        rs_ready      = 1'b0;
        rs_rob_id     = 3'd0;
        rs_value      = 32'd0;
        lsb_ready     = 1'b0;
        lsb_rob_id    = 3'd0;
        lsb_value     = 32'd0;
    endtask

    // Advance one clock edge, settle 1 unit past it, then drop the strobes.
    task automatic applyStimulus();
        @(posedge clk_in);
        #1;
        idleInputs();
    endtask

    task automatic issueEntry(input logic [1:0] kind, input logic [4:0] rd, input logic hasValue,
                              input logic [31:0] value, input logic [31:0] pred);
        dec_ready     = 1'b1;
        dec_type      = kind;
        dec_rd        = rd;
        dec_has_value = hasValue;
        dec_value     = value;
        dec_pred_addr = pred;
    endtask

    task automatic broadcastRs(input logic [2:0] id, input logic [31:0] value);
        rs_ready  = 1'b1;
        rs_rob_id = id;
        rs_value  = value;
    endtask

    task automatic broadcastLsb(input logic [2:0] id, input logic [31:0] value);
        lsb_ready  = 1'b1;
        lsb_rob_id = id;
        lsb_value  = value;
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        applyStimulus();
        rst_in = 1'b0;
    endtask

    initial begin
        rdy_in = 1'b1;
        rst_in = 1'b1;
        qj_id  = 3'd0;
        qk_id  = 3'd0;
        idleInputs();
        applyStimulus();
        applyStimulus();
        rst_in = 1'b0;

        // Reset state
        checkOutput("rst rob_full", 32'(rob_full), 32'd0);
        checkOutput("rst issue_id", 32'(issue_rob_id), 32'd0);
        checkOutput("rst head_id", 32'(head_rob_id), 32'd0);
        checkOutput("rst commit_valid", 32'(commit_valid), 32'd0);
        checkOutput("rst store_commit", 32'(store_commit), 32'd0);
        checkOutput("rst clear", 32'(clear), 32'd0);
        checkOutput("rst clear_pc", clear_pc, 32'd0);
        checkOutput("rst halt", 32'(halt), 32'd0);

        // Single REG: issue id0, rs result, retire
        issueEntry(T_REG, 5'd5, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        checkOutput("s1 issue_id", 32'(issue_rob_id), 32'd1);
        broadcastRs(3'd0, 32'h2A);
        applyStimulus();
        checkOutput("s1 no early commit", 32'(commit_valid), 32'd0);
        applyStimulus();
        checkOutput("s1 commit_valid", 32'(commit_valid), 32'd1);
        checkOutput("s1 commit_rd", 32'(commit_rd), 32'd5);
        checkOutput("s1 commit_value", commit_value, 32'h2A);
        checkOutput("s1 commit_id", 32'(commit_rob_id), 32'd0);
        checkOutput("s1 head", 32'(head_rob_id), 32'd1);
        applyStimulus();
        checkOutput("s1 pulse end", 32'(commit_valid), 32'd0);

        // Out-of-order completion (ids 1,2,3 finish as 3,1,2), in-order retire
        issueEntry(T_REG, 5'd1, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        issueEntry(T_REG, 5'd2, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        issueEntry(T_REG, 5'd3, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        broadcastRs(3'd3, 32'h33);
        applyStimulus();
        checkOutput("s2 blocked by head", 32'(commit_valid), 32'd0);
        broadcastRs(3'd1, 32'h11);
        applyStimulus();
        checkOutput("s2 still blocked", 32'(commit_valid), 32'd0);
        broadcastRs(3'd2, 32'h22);
        applyStimulus();
        checkOutput("s2 c1 valid", 32'(commit_valid), 32'd1);
        checkOutput("s2 c1 id", 32'(commit_rob_id), 32'd1);
        checkOutput("s2 c1 value", commit_value, 32'h11);
        applyStimulus();
        checkOutput("s2 c2 id", 32'(commit_rob_id), 32'd2);
        checkOutput("s2 c2 value", commit_value, 32'h22);
        applyStimulus();
        checkOutput("s2 c3 id", 32'(commit_rob_id), 32'd3);
        checkOutput("s2 c3 value", commit_value, 32'h33);
        applyStimulus();
        checkOutput("s2 drained", 32'(commit_valid), 32'd0);
        checkOutput("s2 head", 32'(head_rob_id), 32'd4);

        // Fill all 8 entries, then retire and issue in the same cycle
        doReset();
        for (int i = 0; i < 8; i++) begin
            issueEntry(T_REG, 5'(10 + i), 1'b0, 32'd0, 32'd0);
            applyStimulus();
        end
        checkOutput("s3 full", 32'(rob_full), 32'd1);
        checkOutput("s3 tail wrapped", 32'(issue_rob_id), 32'd0);
        broadcastRs(3'd0, 32'h77);
        applyStimulus();
        issueEntry(T_REG, 5'd20, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        checkOutput("s3 commit while full", 32'(commit_valid), 32'd1);
        checkOutput("s3 commit value", commit_value, 32'h77);
        checkOutput("s3 still full", 32'(rob_full), 32'd1);
        checkOutput("s3 tail", 32'(issue_rob_id), 32'd1);
        checkOutput("s3 head", 32'(head_rob_id), 32'd1);

        // Dual broadcast with same-cycle operand bypass
        broadcastRs(3'd1, 32'hAAAA);
        broadcastLsb(3'd3, 32'hBBBB);
        qj_id = 3'd3;
        qk_id = 3'd1;
        #1;
        checkOutput("s6 qj_ready bypass", 32'(qj_ready), 32'd1);
        checkOutput("s6 qj_value lsb", qj_value, 32'hBBBB);
        checkOutput("s6 qk_ready bypass", 32'(qk_ready), 32'd1);
        checkOutput("s6 qk_value rs", qk_value, 32'hAAAA);
        applyStimulus();
        checkOutput("s6 qj stored ready", 32'(qj_ready), 32'd1);
        checkOutput("s6 qj stored value", qj_value, 32'hBBBB);
        qk_id = 3'd5;
        #1;
        checkOutput("s6 qk not ready", 32'(qk_ready), 32'd0);
        applyStimulus();
        checkOutput("s6 commit id1", 32'(commit_rob_id), 32'd1);
        checkOutput("s6 commit value", commit_value, 32'hAAAA);

        // Reset in the middle of traffic
        rst_in = 1'b1;
        broadcastRs(3'd2, 32'h1234);
        issueEntry(T_REG, 5'd1, 1'b1, 32'h1, 32'd0);
        applyStimulus();
        rst_in = 1'b0;
        checkOutput("s5 commit_valid", 32'(commit_valid), 32'd0);
        checkOutput("s5 rob_full", 32'(rob_full), 32'd0);
        checkOutput("s5 tail", 32'(issue_rob_id), 32'd0);
        checkOutput("s5 head", 32'(head_rob_id), 32'd0);
        applyStimulus();
        checkOutput("s5 no commit after", 32'(commit_valid), 32'd0);
        checkOutput("s5 no store", 32'(store_commit), 32'd0);

        // Mispredicted branch: flush, redirect, drop younger entries
        issueEntry(T_BRANCH, 5'd0, 1'b0, 32'd0, 32'h104);
        applyStimulus();
        issueEntry(T_REG, 5'd7, 1'b1, 32'h55, 32'd0);
        applyStimulus();
        issueEntry(T_REG, 5'd8, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        broadcastRs(3'd0, 32'h200);
        applyStimulus();
        checkOutput("s4 no clear yet", 32'(clear), 32'd0);
        applyStimulus();
        checkOutput("s4 clear", 32'(clear), 32'd1);
        checkOutput("s4 clear_pc", clear_pc, 32'h200);
        checkOutput("s4 no reg commit", 32'(commit_valid), 32'd0);
        issueEntry(T_REG, 5'd9, 1'b1, 32'h66, 32'd0);
        broadcastRs(3'd2, 32'h3);
        applyStimulus();
        checkOutput("s4 clear drops", 32'(clear), 32'd0);
        checkOutput("s4 tail reset", 32'(issue_rob_id), 32'd0);
        checkOutput("s4 head reset", 32'(head_rob_id), 32'd0);
        checkOutput("s4 not full", 32'(rob_full), 32'd0);
        applyStimulus();
        checkOutput("s4 younger dropped", 32'(commit_valid), 32'd0);

        // rdy_in low holds everything
        issueEntry(T_REG, 5'd9, 1'b1, 32'h99, 32'd0);
        applyStimulus();
        checkOutput("s7 issued", 32'(issue_rob_id), 32'd1);
        rdy_in = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("s7 frozen commit", 32'(commit_valid), 32'd0);
        checkOutput("s7 frozen head", 32'(head_rob_id), 32'd0);
        checkOutput("s7 frozen tail", 32'(issue_rob_id), 32'd1);
        rdy_in = 1'b1;
        applyStimulus();
        checkOutput("s7 commit", 32'(commit_valid), 32'd1);
        checkOutput("s7 commit rd", 32'(commit_rd), 32'd9);
        checkOutput("s7 commit value", commit_value, 32'h99);
        rdy_in = 1'b0;
        applyStimulus();
        checkOutput("s7 strobe held", 32'(commit_valid), 32'd1);
        rdy_in = 1'b1;
        applyStimulus();
        checkOutput("s7 strobe ends", 32'(commit_valid), 32'd0);

        // Store retires on its lsb completion
        issueEntry(T_STORE, 5'd0, 1'b0, 32'd0, 32'd0);
        applyStimulus();
        broadcastLsb(3'd1, 32'hDEAD);
        applyStimulus();
        applyStimulus();
        checkOutput("s8 store_commit", 32'(store_commit), 32'd1);
        checkOutput("s8 store_id", 32'(store_rob_id), 32'd1);
        checkOutput("s8 no reg commit", 32'(commit_valid), 32'd0);
        applyStimulus();
        checkOutput("s8 store pulse end", 32'(store_commit), 32'd0);

        // Halt is sticky and blocks later retires
        issueEntry(T_HALT, 5'd0, 1'b1, 32'd0, 32'd0);
        applyStimulus();
        issueEntry(T_REG, 5'd4, 1'b1, 32'h44, 32'd0);
        applyStimulus();
        checkOutput("s9 halt set", 32'(halt), 32'd1);
        applyStimulus();
        checkOutput("s9 no commit", 32'(commit_valid), 32'd0);
        checkOutput("s9 head", 32'(head_rob_id), 32'd3);
        applyStimulus();
        checkOutput("s9 halt sticky", 32'(halt), 32'd1);
        checkOutput("s9 still no commit", 32'(commit_valid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
